// File: rtl/mem_cache_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage cache: widths, FSM states, address helpers.
package mem_cache_sram_ctrl_pkg;

  localparam int unsigned LINE_W = 64;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    DONE
  } state_t;

  // Byte offset of an address relative to the SRAM window base.
  function automatic logic [31:0] addr_offset(input logic [31:0] address,
                                              input logic [31:0] base);
    return address - base;
  endfunction

  // Select one 32-bit word out of a 64-bit line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic              sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/mem_cache_sram_ctrl_if.sv
// Pipeline-side request/response bundle between EXE/MEM and the cache controller.
interface mem_cache_sram_ctrl_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, w_data,
    input  r_data, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, w_data,
    output r_data, ready
  );

endinterface

// File: rtl/mem_cache_sram_ctrl_tag_array.sv
// Valid/tag/data/LRU storage: combinational read of all ways at one index, one write port.
module mem_cache_sram_ctrl_tag_array
  import mem_cache_sram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned SET_BITS = 6,
  parameter int unsigned TAG_W    = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] index,
  output logic [NUM_WAYS-1:0] rd_valid,
  output logic [TAG_W-1:0]    rd_tag  [NUM_WAYS],
  output logic [LINE_W-1:0]   rd_data [NUM_WAYS],
  output logic                rd_lru,
  input  logic                wr_en,
  input  logic                wr_fill,
  input  logic                wr_way,
  input  logic [1:0]          wr_word_en,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [LINE_W-1:0]   wr_data,
  input  logic                lru_we,
  input  logic                lru_val
);

  localparam int unsigned SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid_q [NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_WAYS][SETS];
  logic [LINE_W-1:0] data_q  [NUM_WAYS][SETS];

  // Read port: every way at the requested index.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      rd_valid[w] = valid_q[w][index];
      rd_tag[w]   = tag_q[w][index];
      rd_data[w]  = data_q[w][index];
    end
  end

  // Valid bits: cleared on reset, set by a line fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_way][index] <= 1'b1;
    end
  end

  // Tag and data storage; per-word enables let a store hit touch one half only.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_word_en[0]) data_q[wr_way][index][WORD_W-1:0]      <= wr_data[WORD_W-1:0];
      if (wr_word_en[1]) data_q[wr_way][index][LINE_W-1:WORD_W] <= wr_data[LINE_W-1:WORD_W];
      if (wr_fill)       tag_q[wr_way][index]                   <= wr_tag;
    end
  end

  if (NUM_WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;

    // One LRU bit per set names the way to evict next.
    always_ff @(posedge clk) begin
      if (rst)         lru_q        <= '0;
      else if (lru_we) lru_q[index] <= lru_val;
    end

    assign rd_lru = lru_q[index];
  end else begin : g_no_lru
    assign rd_lru = 1'b0;
  end

endmodule

// File: rtl/mem_cache_sram_ctrl.sv
// Memory-stage write-through, no-write-allocate cache in front of a 64-bit SRAM.
module mem_cache_sram_ctrl
  import mem_cache_sram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WAYS  = 2,
  parameter int unsigned SET_BITS  = 6,
  parameter int unsigned SRAM_AW   = 17,
  parameter int unsigned SRAM_WAIT = 5,
  parameter int unsigned ADDR_BASE = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_cache_sram_ctrl_if.slave   bus,
  inout  wire  [LINE_W-1:0]      sram_dq,
  output logic [SRAM_AW-1:0]     sram_address,
  output logic                   sram_we_n
);

  localparam int unsigned TAG_W = SRAM_AW - SET_BITS;
  localparam int unsigned CNT_W = $clog2(SRAM_WAIT + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   fill_q;

  logic [31:0]         off;
  logic                word_sel;
  logic [SET_BITS-1:0] index;
  logic [TAG_W-1:0]    tag;
  logic [SRAM_AW-1:0]  line_addr;
  logic                unused_off;
  logic                rd_only;

  logic [NUM_WAYS-1:0] way_valid;
  logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
  logic [LINE_W-1:0]   way_data [NUM_WAYS];
  logic                lru_way;
  logic                victim;

  logic                hit;
  logic                hit_way;
  logic [LINE_W-1:0]   hit_line;

  logic                ready;
  logic [WORD_W-1:0]   r_data;
  logic                arr_we;
  logic                arr_fill;
  logic                arr_way;
  logic [1:0]          arr_word_en;
  logic [LINE_W-1:0]   arr_wdata;
  logic                lru_we;
  logic                lru_val;
  logic                cnt_load;

  assign off        = addr_offset(bus.address, 32'(ADDR_BASE));
  assign word_sel   = off[2];
  assign index      = off[3 +: SET_BITS];
  assign tag        = off[SRAM_AW+2 : 3+SET_BITS];
  assign line_addr  = off[SRAM_AW+2 : 3];
  assign unused_off = ^{off[31:SRAM_AW+3], off[1:0]};
  assign rd_only    = bus.mem_r_en && !bus.mem_w_en;
  assign victim     = (NUM_WAYS == 2) ? lru_way : 1'b0;

  mem_cache_sram_ctrl_tag_array #(
    .NUM_WAYS (NUM_WAYS),
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W)
  ) u_tag_array (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .rd_valid   (way_valid),
    .rd_tag     (way_tag),
    .rd_data    (way_data),
    .rd_lru     (lru_way),
    .wr_en      (arr_we),
    .wr_fill    (arr_fill),
    .wr_way     (arr_way),
    .wr_word_en (arr_word_en),
    .wr_tag     (tag),
    .wr_data    (arr_wdata),
    .lru_we     (lru_we),
    .lru_val    (lru_val)
  );

  // Tag compare across all ways.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_line = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_line = way_data[w];
      end
    end
  end

  // Fills take the line from the SRAM bus; store hits write the replicated word.
  assign arr_wdata = (state_q == RD_MISS) ? sram_dq : {2{bus.w_data}};

  // Next-state, pipeline handshake and cache-array write controls.
  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    r_data      = '0;
    arr_we      = 1'b0;
    arr_fill    = 1'b0;
    arr_way     = hit_way;
    arr_word_en = '0;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    cnt_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_w_en) begin
          state_d  = WR_THRU;
          cnt_load = 1'b1;
          if (hit) begin
            arr_we      = 1'b1;
            arr_word_en = word_sel ? 2'b10 : 2'b01;
          end
        end else if (bus.mem_r_en) begin
          if (hit) begin
            ready   = 1'b1;
            r_data  = line_word(hit_line, word_sel);
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            state_d  = RD_MISS;
            cnt_load = 1'b1;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        if (cnt_q == '0) begin
          arr_we      = 1'b1;
          arr_fill    = 1'b1;
          arr_way     = victim;
          arr_word_en = 2'b11;
          lru_we      = 1'b1;
          lru_val     = ~victim;
          state_d     = DONE;
        end
      end
      WR_THRU: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
        if (rd_only) r_data = line_word(fill_q, word_sel);
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // SRAM wait counter and captured fill line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fill_q <= '0;
    end else begin
      if (cnt_load)          cnt_q <= CNT_W'(SRAM_WAIT - 1);
      else if (cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
      if (arr_fill)          fill_q <= sram_dq;
    end
  end

  assign bus.ready    = ready;
  assign bus.r_data   = r_data;
  assign sram_we_n    = (state_q != WR_THRU);
  assign sram_address = ((state_q == RD_MISS) || (state_q == WR_THRU)) ? line_addr : '0;
  assign sram_dq      = (state_q == WR_THRU) ? {2{bus.w_data}} : 'z;

endmodule
